// File: rtl/fifo_ram.sv
// Single-clock simple dual-port storage for sync_fifo: one write port, one
// registered read port, no reset so it maps onto block RAM.
module fifo_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // rd_data holds its value whenever no read is enabled
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO: pointer/count control with registered status flags,
// sticky overflow/underflow and a synchronous flush.
module sync_fifo #(
    parameter int unsigned DATA_WIDTH        = 8,
    parameter int unsigned ADDR_WIDTH        = 4,
    parameter int unsigned ALMOST_FULL_LEVEL = (1 << ADDR_WIDTH) - 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  we,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH + 1)'(ALMOST_FULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_ok;
    logic                  rd_ok;

    // Flags come from the registered count only, never from the pointers
    always_comb begin
        full        = (count == DEPTH_CNT);
        empty       = (count == '0);
        almost_full = (count >= AF_CNT);
        wr_ok       = we & ~full & ~clear;
        rd_ok       = re & ~empty & ~clear;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            data_valid <= rd_ok;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (we && full) begin
                overflow <= 1'b1;
            end
            if (re && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a vector table of per-cycle inputs and
// hand-computed results, plus an asynchronous-reset sequence.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clear;
    logic [7:0] data_in;
    logic       we;
    logic       re;
    logic [7:0] data_out;
    logic       data_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sync_fifo #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .data_in     (data_in),
        .we          (we),
        .re          (re),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    typedef struct {
        logic       we;
        logic       re;
        logic       clr;
        logic [7:0] din;
        logic [4:0] cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       dv;
        logic       chk;
        logic [7:0] dout;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    function automatic void add(input logic w, input logic r, input logic c,
                                input logic [7:0] din, input int cnt,
                                input logic dv, input logic chk, input logic [7:0] dout,
                                input logic ovf, input logic unf);
        vec_t v;
        v.we    = w;
        v.re    = r;
        v.clr   = c;
        v.din   = din;
        v.cnt   = 5'(cnt);
        v.full  = (cnt == 16);
        v.empty = (cnt == 0);
        v.af    = (cnt >= 14);
        v.dv    = dv;
        v.chk   = chk;
        v.dout  = dout;
        v.ovf   = ovf;
        v.unf   = unf;
        vecs.push_back(v);
    endfunction

    initial begin
        reset_n = 1'b0;
        clear   = 1'b0;
        we      = 1'b0;
        re      = 1'b0;
        data_in = '0;

        // Fill 0x01..0x10, then one rejected write
        for (int i = 0; i < 16; i++) add(1, 0, 0, 8'(i + 1), i + 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 8'h11, 16, 0, 0, 0, 1, 0);
        // Drain in order, then one rejected read; data_out holds 0x10
        for (int i = 0; i < 16; i++) add(0, 1, 0, 8'h00, 15 - i, 1, 1, 8'(i + 1), 1, 0);
        add(0, 1, 0, 8'h00, 0, 0, 1, 8'h10, 1, 1);
        add(0, 0, 1, 8'h00, 0, 0, 0, 0, 0, 0);
        // count=5 then streaming across pointer wrap
        for (int i = 0; i < 5; i++) add(1, 0, 0, 8'(8'h20 + i), i + 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) add(1, 1, 0, 8'(8'h25 + i), 5, 1, 1, 8'(8'h20 + i), 0, 0);
        for (int i = 0; i < 5; i++) add(0, 1, 0, 8'h00, 4 - i, 1, 1, 8'(8'h34 + i), 0, 0);
        // Simultaneous we/re on empty
        add(1, 1, 0, 8'hAA, 1, 0, 0, 0, 0, 1);
        add(0, 1, 0, 8'h00, 0, 1, 1, 8'hAA, 0, 1);
        add(0, 0, 1, 8'h00, 0, 0, 0, 0, 0, 0);
        // Reach count=7 with overflow set, then clear with we/re ignored
        for (int i = 0; i < 16; i++) add(1, 0, 0, 8'(8'h60 + i), i + 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 8'hEE, 16, 0, 0, 0, 1, 0);
        for (int i = 0; i < 9; i++) add(0, 1, 0, 8'h00, 15 - i, 1, 1, 8'(8'h60 + i), 1, 0);
        add(1, 1, 1, 8'h99, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 8'h55, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 8'h00, 0, 1, 1, 8'h55, 0, 0);
        add(0, 0, 0, 8'h00, 0, 0, 1, 8'h55, 0, 0);

        #12;
        check("rst_count", -1, 32'(count), 32'd0);
        check("rst_empty", -1, 32'(empty), 32'd1);
        check("rst_full", -1, 32'(full), 32'd0);
        check("rst_af", -1, 32'(almost_full), 32'd0);
        check("rst_dv", -1, 32'(data_valid), 32'd0);
        check("rst_ovf", -1, 32'(overflow), 32'd0);
        check("rst_unf", -1, 32'(underflow), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            we      = vecs[i].we;
            re      = vecs[i].re;
            clear   = vecs[i].clr;
            data_in = vecs[i].din;
            @(posedge clk);
            #1;
            check("count", i, 32'(count), 32'(vecs[i].cnt));
            check("full", i, 32'(full), 32'(vecs[i].full));
            check("empty", i, 32'(empty), 32'(vecs[i].empty));
            check("almost_full", i, 32'(almost_full), 32'(vecs[i].af));
            check("data_valid", i, 32'(data_valid), 32'(vecs[i].dv));
            check("overflow", i, 32'(overflow), 32'(vecs[i].ovf));
            check("underflow", i, 32'(underflow), 32'(vecs[i].unf));
            if (vecs[i].chk) check("data_out", i, 32'(data_out), 32'(vecs[i].dout));
        end

        // Asynchronous reset in the middle of a burst
        @(negedge clk);
        we = 1'b1; re = 1'b0; clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_in = 8'(8'h31 + i);
            @(negedge clk);
        end
        we = 1'b0; re = 1'b1;
        @(posedge clk);
        #1;
        check("pre_arst_count", -2, 32'(count), 32'd2);
        check("pre_arst_dv", -2, 32'(data_valid), 32'd1);
        @(negedge clk);
        re = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_count", -2, 32'(count), 32'd0);
        check("arst_empty", -2, 32'(empty), 32'd1);
        check("arst_dv", -2, 32'(data_valid), 32'd0);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        we = 1'b1; data_in = 8'h77;
        @(posedge clk);
        #1;
        check("post_arst_count", -2, 32'(count), 32'd1);
        @(negedge clk);
        we = 1'b0; re = 1'b1;
        @(posedge clk);
        #1;
        check("post_arst_dout", -2, 32'(data_out), 32'h77);
        check("post_arst_dv", -2, 32'(data_valid), 32'd1);
        check("post_arst_empty", -2, 32'(empty), 32'd1);
        @(negedge clk);
        re = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 4, log2 of depth; DEPTH = 1 << ADDR_WIDTH words.
REQ-003 Parameter ALMOST_FULL_LEVEL, default DEPTH-2, count at or above which almost_full asserts.
REQ-004 Port clk  input  1  single clock for the block; all state changes on rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port clear  input  1  synchronous flush, active-high.
REQ-007 Port data_in  input  DATA_WIDTH  write data.
REQ-008 Port we  input  1  write request.
REQ-009 Port re  input  1  read request.
REQ-010 Port data_out  output  DATA_WIDTH  read data.
REQ-011 Port data_valid  output  1  data_out holds a newly read word this cycle.
REQ-012 Port full, empty, almost_full  output  1 each  status flags.
REQ-013 Port count  output  ADDR_WIDTH+1  words currently stored, 0..DEPTH.
REQ-014 Port overflow, underflow  output  1 each  sticky error flags.

Function
REQ-015 Write accepted iff we=1 and full=0; word stored at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-016 Read accepted iff re=1 and empty=0; ram[rd_ptr] registered to data_out at that edge, rd_ptr increments modulo DEPTH.
REQ-017 Read latency one cycle: data_valid=1 in the cycle after an accepted-read edge, else 0.
REQ-018 data_out holds its last value when no read is accepted.
REQ-019 count: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-020 Simultaneous we and re when full: read accepted, write rejected, overflow set.
REQ-021 Simultaneous we and re when empty: write accepted, read rejected, underflow set.
REQ-022 full = (count == DEPTH), empty = (count == 0), almost_full = (count >= ALMOST_FULL_LEVEL), all decoded from registered count only.
REQ-023 Word written at edge N is readable by a read accepted at edge N+1 (no read-during-write bypass needed).
REQ-024 overflow sets on we=1 while full=0 is false and write rejected; underflow sets on re=1 while empty; both stay set until reset or clear.
REQ-025 clear=1: pointers, count, data_valid, overflow, underflow to 0 at next edge; we/re ignored that cycle; RAM contents untouched.
REQ-026 Pointers are ADDR_WIDTH bits and wrap silently; full/empty never derived from pointer comparison.

Reset
REQ-027 reset_n low asynchronously forces wr_ptr, rd_ptr, count, data_valid, overflow, underflow to 0; empty=1, full=0, almost_full=0.
REQ-028 data_out and RAM array are not reset (block-RAM inference); data_out undefined until first data_valid.
REQ-029 Reset mid-operation discards all stored words; first write after release lands at address 0.

Structure
REQ-030 No shared package; DEPTH is a localparam derived from ADDR_WIDTH inside the module.
REQ-031 Storage in one sub-module fifo_ram: single-clock simple dual-port RAM, registered read, write-enable, no reset, parameters DATA_WIDTH/ADDR_WIDTH.
REQ-032 Control (pointers, count, flags) in sync_fifo itself; no combinational path from we/re to full/empty/count.

Verification
REQ-033 Defaults; write 0x01..0x10 (16 words) -> full=1 after 16th edge, count=16, almost_full from count=14; 17th write -> overflow=1, count stays 16.
REQ-034 From full, read 16 times -> data_out 0x01..0x10 in order, each with data_valid one cycle after re; empty=1 after last; extra re -> underflow=1.
REQ-035 count=5, we=re=1 for 20 cycles -> count stays 5, order preserved across pointer wrap, no error flags.
REQ-036 Empty, we=re=1 with 0xAA -> count=1, data_valid=0, underflow=1; next cycle re -> data_out=0xAA with data_valid=1.
REQ-037 count=7 with overflow=1, pulse clear -> count=0, empty=1, overflow=0; write 0x55 then read -> 0x55.
REQ-038 Assert reset_n low between clock edges mid-burst -> count=0, empty=1, data_valid=0 immediately without clock edge.
